// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), plus an absorbing TRAP.
// Define RV32I_BJU_EN to add branch, LUI, AUIPC, JAL and JALR support; otherwise those opcodes trap.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic       legal;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
`ifdef RV32I_BJU_EN
  assign is_br    = (opcode == OP_BR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
`else
  assign is_br    = 1'b0;
  assign is_lui   = 1'b0;
  assign is_auipc = 1'b0;
  assign is_jal   = 1'b0;
  assign is_jalr  = 1'b0;
`endif

  assign legal = (instr[1:0] == 2'b11) &&
                 (is_r || is_i || is_ld || is_st || is_br || is_lui || is_auipc || is_jal || is_jalr);

  // Datapath selects depend only on the IR, so they are valid in every state.
  always_comb begin
    imm_sel   = 3'd0;
    alu_a_sel = is_auipc;
    alu_b_sel = is_i | is_ld | is_st | is_jalr | is_auipc | is_lui;
    alu_ctrl  = 4'b0000;
    wb_sel    = 2'd0;
    if (is_st)             imm_sel = 3'd1;
    if (is_br)             imm_sel = 3'd2;
    if (is_lui | is_auipc) imm_sel = 3'd3;
    if (is_jal)            imm_sel = 3'd4;
    if (is_r)              alu_ctrl = {funct7_5, funct3};
    if (is_i)              alu_ctrl = {(funct3 == 3'b101) & funct7_5, funct3};
    if (is_ld)             wb_sel = 2'd1;
    if (is_jal | is_jalr)  wb_sel = 2'd2;
    if (is_lui)            wb_sel = 2'd3;
  end

  // Strobes are Moore per state, qualified only by the ready/br_taken inputs of that state.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = rst_n;
        if (rst_n && imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_br) begin
          pc_we   = br_taken;
          pc_sel  = 2'd1;
          state_d = S_FETCH;
        end else begin
          if (is_jal) begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
          end
          if (is_jalr) begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
          end
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ready) state_d = is_ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign illegal = (state_q == S_TRAP);
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-cycle expected trace is built from the instruction-class rules.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, br_taken = 1'b0;
  logic        imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel;
  logic        dmem_req, dmem_we, rf_we, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [3:0]  alu_ctrl;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_LUI = 5;
  localparam int C_AUIPC = 6, C_JAL = 7, C_JALR = 8, C_ILL = 9;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectation: {state[2:0], imem_req, ir_we, pc_we, pc_sel[1:0], dmem_req, dmem_we, rf_we, wb_sel[1:0], illegal}
  logic [13:0] exp_q[$];
  // Per-cycle stimulus: {imem_ready, dmem_ready, br_taken}
  logic [2:0]  stim_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cls(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
`ifdef RV32I_BJU_EN
      7'b1100011: return C_BR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
`endif
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [13:0] mk(input logic [2:0] st, input logic imem, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic dreq,
                                     input logic dwe, input logic rfw, input logic [1:0] wbs,
                                     input logic ill);
    return {st, imem, irw, pcw, pcs, dreq, dwe, rfw, wbs, ill};
  endfunction

  function automatic logic [2:0] rnd3();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input logic [13:0] e, input logic [2:0] s);
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Expected cycles of one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic build_trace(input logic [31:0] ins, input int fw, input int mw, input logic taken);
    int c;
    logic [1:0] wbs;
    c = cls(ins);
    for (int i = 0; i < fw; i++) push(mk(3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0), {1'b0, 2'($urandom_range(0, 3))});
    push(mk(3'd0, 1, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0), {1'b1, 2'($urandom_range(0, 3))});
    push(mk(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0), rnd3());
    if (c == C_ILL) begin
      for (int i = 0; i < 4; i++) push(mk(3'd5, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1), rnd3());
      return;
    end
    case (c)
      C_BR:    push(mk(3'd2, 0, 0, taken, 2'd1, 0, 0, 0, 2'd0, 0), {2'($urandom_range(0, 3)), taken});
      C_JAL:   push(mk(3'd2, 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0), rnd3());
      C_JALR:  push(mk(3'd2, 0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0), rnd3());
      default: push(mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0), rnd3());
    endcase
    if (c == C_BR) return;
    if (c == C_LD || c == C_ST) begin
      for (int i = 0; i < mw; i++)
        push(mk(3'd3, 0, 0, 0, 2'd0, 1, c == C_ST, 0, 2'd0, 0), {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))});
      push(mk(3'd3, 0, 0, 0, 2'd0, 1, c == C_ST, 0, 2'd0, 0), {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))});
      if (c == C_ST) return;
    end
    wbs = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : (c == C_LUI) ? 2'd3 : 2'd0;
    push(mk(3'd4, 0, 0, 0, 2'd0, 0, 0, 1, wbs, 0), rnd3());
  endtask

  task automatic check_decode(input logic [31:0] ins, input int c);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (c)
      C_R: begin
        check_eq("alu_ctrl_r", 32'(alu_ctrl), 32'({ins[30], f3}));
        check_eq("alu_sel_r", 32'({alu_a_sel, alu_b_sel}), 32'(0));
      end
      C_I: begin
        check_eq("alu_ctrl_i", 32'(alu_ctrl), 32'({(f3 == 3'b101) & ins[30], f3}));
        check_eq("alu_sel_i", 32'({alu_a_sel, alu_b_sel}), 32'(1));
        check_eq("imm_sel_i", 32'(imm_sel), 32'(0));
      end
      C_LD, C_ST: begin
        check_eq("alu_ctrl_mem", 32'(alu_ctrl), 32'(0));
        check_eq("alu_sel_mem", 32'({alu_a_sel, alu_b_sel}), 32'(1));
        check_eq("imm_sel_mem", 32'(imm_sel), (c == C_ST) ? 32'(1) : 32'(0));
      end
      C_BR:    check_eq("imm_sel_b", 32'(imm_sel), 32'(2));
      C_LUI:   check_eq("imm_sel_u", 32'(imm_sel), 32'(3));
      C_AUIPC: begin
        check_eq("imm_sel_u", 32'(imm_sel), 32'(3));
        check_eq("alu_sel_auipc", 32'({alu_a_sel, alu_b_sel}), 32'(3));
      end
      C_JAL:   check_eq("imm_sel_j", 32'(imm_sel), 32'(4));
      C_JALR: begin
        check_eq("imm_sel_jalr", 32'(imm_sel), 32'(0));
        check_eq("alu_b_jalr", 32'(alu_b_sel), 32'(1));
      end
      default: ;
    endcase
  endtask

  // Entered and left at posedge+1; outputs are sampled mid-cycle.
  task automatic run_cycles(input logic [31:0] ins, input int n);
    logic [13:0] e, o;
    logic [2:0]  s;
    instr = ins;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      {imem_ready, dmem_ready, br_taken} = s;
      #3;
      o = {state_o, imem_req, ir_we, pc_we, e[8] ? pc_sel : 2'b00, dmem_req, dmem_we,
           rf_we, e[3] ? wb_sel : 2'b00, illegal};
      check_eq($sformatf("cycle_st%0d_%h", e[13:11], ins), 32'(o), 32'(e));
      if (e[13:11] == 3'd1) check_decode(ins, cls(ins));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] strobes();
    return {state_o, imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we, illegal};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'($urandom_range(0, 1));
    #1;
    check_eq("rst_async", 32'(strobes()), 32'(0));
    @(posedge clk);
    #1;
    check_eq("rst_hold", 32'(strobes()), 32'(0));
    imem_ready = 1'b0;
    rst_n = 1'b1;
    #3;
    check_eq("first_req", 32'(strobes()), 32'(10'b000_1000000));
    @(posedge clk);
    #1;
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic taken);
    build_trace(ins, fw, mw, taken);
    run_cycles(ins, 1000);
    if (cls(ins) == C_ILL) do_reset();
  endtask

  logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);  // ADDI x1,x0,5
    run_instr(32'h0000A103, 1, 2, 1'b0);  // LW, two memory wait cycles
    run_instr(32'h0020A023, 0, 0, 1'b0);  // SW
    run_instr(32'h00208063, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00208063, 0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h0000006F, 0, 0, 1'b0);  // JAL
    run_instr(32'h4030D093, 0, 0, 1'b0);  // SRAI
    run_instr(32'h0000007F, 0, 0, 1'b0);  // unsupported opcode
    run_instr(32'h00000031, 0, 0, 1'b0);  // instr[1:0] != 11
    // Reset in the middle of a data access.
    build_trace(32'h0000A103, 0, 5, 1'b0);
    run_cycles(32'h0000A103, 5);
    do_reset();
    // Reset while a fetch is still waiting.
    build_trace(32'h00500093, 4, 0, 1'b0);
    run_cycles(32'h00500093, 2);
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      ins = {25'($urandom), ops[$urandom_range(0, 9)]};
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 instr  in  32  current IR contents; opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
REQ-004 imem_ready  in  1  fetch data valid on instruction port.
REQ-005 dmem_ready  in  1  data access complete.
REQ-006 br_taken  in  1  branch-compare result from ALU; sampled in EXEC only.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 ir_we  out  1  IR and captured-PC load strobe.
REQ-009 pc_we  out  1  PC write strobe.
REQ-010 pc_sel  out  2  PC source: 0 = pc+4, 1 = captured_pc+imm, 2 = ALU result with bit0 cleared.
REQ-011 imm_sel  out  3  immediate format to extender: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
REQ-012 alu_a_sel  out  1  ALU A source: 0 = rs1, 1 = captured PC.
REQ-013 alu_b_sel  out  1  ALU B source: 0 = rs2, 1 = imm_ext.
REQ-014 alu_ctrl  out  4  ALU operation: {funct7[5], funct3} or 4'b0000 (ADD).
REQ-015 dmem_req / dmem_we  out  1 / 1  data request; write qualifier.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4, 3 = imm_ext.
REQ-018 illegal  out  1  sticky illegal-instruction flag.
REQ-019 state_o  out  3  current state, for debug.

Function
REQ-020 The FSM SHALL have these states: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
REQ-021 FETCH:
- imem_req = 1 while rst_n is high.
- Holds until imem_ready.
- On the imem_ready cycle: ir_we = 1, pc_we = 1, pc_sel = 0; next state DECODE.
REQ-022 DECODE (one cycle, no strobes): unsupported opcode, or instr[1:0] != 2'b11 -> TRAP; otherwise -> EXEC.
REQ-023 imm_sel and the ALU selects SHALL be decoded from instr combinationally in every state; strobes SHALL be Moore per state plus the listed handshake qualifiers.
REQ-024 EXEC, by instruction class:
- R-type: alu_ctrl = {funct7[5], funct3}.
- I-arith: alu_b_sel = 1; alu_ctrl = {funct7[5] only when funct3 = 101, else 0, funct3}.
- load/store: ADD with imm -> MEM.
- R/I-arith/LUI/AUIPC/JAL/JALR -> WB.
REQ-025 EXEC redirects:
- JAL: pc_we = 1, pc_sel = 1.
- JALR: pc_we = 1, pc_sel = 2.
- B-type: pc_we = br_taken, pc_sel = 1, next state FETCH (3 cycles with zero wait).
REQ-026 MEM:
- dmem_req = 1 held until dmem_ready; dmem_we = 1 for stores.
- On dmem_ready: load -> WB, store -> FETCH.
REQ-027 WB: rf_we = 1 for exactly one cycle, with wb_sel per class (load = 1, JAL/JALR = 2, LUI = 3, else 0); next state FETCH.
REQ-028 Latency with zero wait states: ALU/jump 4 cycles, load 5, store 4, branch 3; each imem/dmem wait cycle adds one cycle.
REQ-029 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-030 TRAP SHALL be absorbing until reset: illegal = 1 and all strobes/requests 0.

Reset
REQ-031 rst_n low SHALL force state = FETCH immediately (asynchronous), illegal = 0, and all strobe/request outputs to 0.
REQ-032 The first imem_req SHALL appear in the first cycle with rst_n high.
REQ-033 Reset asserted mid-MEM or mid-FETCH SHALL drop the request without completing; no rf_we or pc_we is issued.

Configuration
REQ-034 With RV32I_BJU_EN defined, B (1100011), LUI (0110111), AUIPC (0010111), JAL (1101111) and JALR (1100111) SHALL be supported.
REQ-035 Without RV32I_BJU_EN, only R, I-arith, load and store SHALL be supported; all other opcodes SHALL go DECODE -> TRAP.

Verification
REQ-036 ADDI x1,x0,5 (0x00500093), imem_ready = 1 -> states 0,1,2,4,0; rf_we high only in WB; alu_b_sel = 1; imm_sel = 0.
REQ-037 LW (0x0000A103) with dmem_ready low 2 cycles -> MEM lasts 3 cycles with dmem_req = 1, dmem_we = 0; then WB with wb_sel = 1.
REQ-038 SW (0x0020A023) -> imm_sel = 1, dmem_we = 1 in MEM; returns to FETCH with no rf_we.
REQ-039 BEQ with br_taken = 1, then with br_taken = 0 (macro defined) -> pc_we = 1, pc_sel = 1 versus pc_we = 0; both take 3 cycles back to FETCH.
REQ-040 Opcode 0x7F, and JAL with the macro undefined -> TRAP with illegal = 1, held until rst_n pulses low.
REQ-041 rst_n pulsed low during MEM -> state 0 asynchronously; dmem_req drops in the same cycle; no rf_we.
